// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// rgb_fade_sequencer: steps through a 4-entry RGB palette, ramping duties
// by 1 LSB per fade tick (or snapping), holding, then advancing.   Rev 1.0
// ============================================================================
module rgb_fade_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [23:0] wr_color,
  input  logic [1:0]  last_idx,
  input  logic        snap,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  duty_red,
  output logic [7:0]  duty_green,
  output logic [7:0]  duty_blue,
  output logic [1:0]  color_idx,
  output logic        busy,
  output logic        step_done
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       palette_q [4];
  logic [23:0]       palette_d [4];
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [1:0]        color_idx_q, color_idx_d;
  logic              busy_q, busy_d;
  logic              step_done_q, step_done_d;
  logic              fade_tick_q, fade_tick_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              tick;
  logic [23:0]       target;
  logic              at_target;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign tick      = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);
  assign target    = palette_q[color_idx_q];
  assign at_target = ({red_q, green_q, blue_q} == target);

  always_comb begin
    state_d     = state_q;
    palette_d   = palette_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    color_idx_d = color_idx_q;
    hold_cnt_d  = hold_cnt_q;
    step_done_d = 1'b0;
    fade_tick_d = 1'b0;

    if (wr_en) palette_d[wr_addr] = wr_color;

    if (state_q == IDLE || tick) tick_cnt_d = '0;
    else                         tick_cnt_d = tick_cnt_q + CNT_W'(1);

    case (state_q)
      FADE: begin
        // Arrival is judged on the cycle after the moving tick, so step_done
        // follows the duty update; an already-matching entry resolves on a tick.
        if (tick) begin
          if (at_target) begin
            state_d     = HOLD;
            step_done_d = 1'b1;
            hold_cnt_d  = '0;
          end else begin
            fade_tick_d = 1'b1;
            if (snap) begin
              {red_d, green_d, blue_d} = target;
            end else begin
              red_d   = step_toward(red_q,   target[23:16]);
              green_d = step_toward(green_q, target[15:8]);
              blue_d  = step_toward(blue_q,  target[7:0]);
            end
          end
        end else if (fade_tick_q && at_target) begin
          state_d     = HOLD;
          step_done_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d  = '0;
            color_idx_d = (color_idx_q >= last_idx) ? 2'd0 : color_idx_q + 2'd1;
            state_d     = FADE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d     = FADE;
      color_idx_d = 2'd0;
      tick_cnt_d  = '0;
      hold_cnt_d  = '0;
      step_done_d = 1'b0;
      fade_tick_d = 1'b0;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
    end

    // stop has priority over a simultaneous start
    if (stop) begin
      state_d     = IDLE;
      tick_cnt_d  = '0;
      step_done_d = 1'b0;
      fade_tick_d = 1'b0;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < 4; i++) palette_q[i] <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      color_idx_q <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      fade_tick_q <= 1'b0;
      tick_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 4; i++) palette_q[i] <= palette_d[i];
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      color_idx_q <= color_idx_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      fade_tick_q <= fade_tick_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign duty_red   = red_q;
  assign duty_green = green_q;
  assign duty_blue  = blue_q;
  assign color_idx  = color_idx_q;
  assign busy       = busy_q;
  assign step_done  = step_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rgb_fade_sequencer: directed stimulus with queued expected duty changes,
// step_done events and status probes checked by a negedge monitor.  Rev 1.0
// ============================================================================
module tb_rgb_fade_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;

  localparam logic [27:0] M_BUSY = 28'h8000000;
  localparam logic [27:0] M_STEP = 28'h4000000;
  localparam logic [27:0] M_IDX  = 28'h3000000;
  localparam logic [27:0] M_DUTY = 28'h0FFFFFF;
  localparam logic [27:0] M_ALL  = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_color;
  logic [1:0]  last_idx;
  logic        snap;
  logic        start;
  logic        stop;
  logic [7:0]  duty_red, duty_green, duty_blue;
  logic [1:0]  color_idx;
  logic        busy;
  logic        step_done;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_color   (wr_color),
    .last_idx   (last_idx),
    .snap       (snap),
    .start      (start),
    .stop       (stop),
    .duty_red   (duty_red),
    .duty_green (duty_green),
    .duty_blue  (duty_blue),
    .color_idx  (color_idx),
    .busy       (busy),
    .step_done  (step_done)
  );

  typedef struct {
    string       name;
    logic [27:0] mask;
    logic [27:0] exp;
  } probe_t;

  logic [23:0] dq [$];
  logic [25:0] sq [$];
  probe_t      pq [$];

  int          checks   = 0;
  int          failures = 0;
  int          stall    = 0;
  logic        mon_en   = 1'b0;
  logic [23:0] prev_duty = '0;
  logic [23:0] duty;
  logic [27:0] obs;
  logic [23:0] exp_d;
  logic [25:0] exp_s;
  probe_t      p;

  assign duty = {duty_red, duty_green, duty_blue};
  assign obs  = {busy, step_done, color_idx, duty};

  always @(negedge clk) begin
    if (mon_en) begin
      if (duty != prev_duty) begin
        checks++;
        stall = 0;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL duty_unexpected got=%h want=none", duty);
        end else begin
          exp_d = dq.pop_front();
          if (duty != exp_d) begin
            failures++;
            $display("FAIL duty got=%h want=%h", duty, exp_d);
          end
        end
      end
      if (step_done) begin
        checks++;
        stall = 0;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL step_unexpected got=%h want=none", {color_idx, duty});
        end else begin
          exp_s = sq.pop_front();
          if ({color_idx, duty} != exp_s) begin
            failures++;
            $display("FAIL step got={idx,rgb}=%h want=%h", {color_idx, duty}, exp_s);
          end
        end
      end
      if (dq.size() != 0 || sq.size() != 0) begin
        stall++;
        if (stall > 400) begin
          checks++;
          failures++;
          $display("FAIL timeout got=pending(duty=%0d,step=%0d) want=0", dq.size(), sq.size());
          dq.delete();
          sq.delete();
          stall = 0;
        end
      end else begin
        stall = 0;
      end
    end
    while (pq.size() != 0) begin
      p = pq.pop_front();
      checks++;
      if ((obs & p.mask) != (p.exp & p.mask)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", p.name, obs & p.mask, p.exp & p.mask, p.mask);
      end
    end
    prev_duty = duty;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] c);
    wr_en = 1'b1; wr_addr = a; wr_color = c;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic probe(input string name, input logic [27:0] mask, input logic [27:0] exp);
    pq.push_back('{name, mask, exp});
    cyc();
  endtask

  task automatic drain();
    while (dq.size() != 0 || sq.size() != 0) cyc();
  endtask

  task automatic exp_step(input logic [1:0] idx, input logic [23:0] rgb);
    sq.push_back({idx, rgb});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_color = '0;
    last_idx = '0; snap = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(2);
    probe("reset_state", M_ALL, 28'h0);
    reset = 1'b0;
    cyc();
    mon_en = 1'b1;

    // Basic ramp towards 0x030100; color_idx stays 0 across the hold
    wr(2'd0, 24'h030100);
    dq.push_back(24'h010100); dq.push_back(24'h020100); dq.push_back(24'h030100);
    exp_step(2'd0, 24'h030100); exp_step(2'd0, 24'h030100);
    pulse_start();
    cyc(2);
    probe("busy_after_start", M_BUSY | M_IDX, 28'h8000000);
    drain();
    pulse_stop();
    cyc(2);
    probe("ramp_stop_idle", M_BUSY | M_IDX | M_DUTY, 28'h0030100);

    // Two-entry snap sequence wrapping 0,1,0,1
    wr(2'd0, 24'h0A0000);
    wr(2'd1, 24'h000A00);
    last_idx = 2'd1; snap = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dq.push_back(24'h0A0000); exp_step(2'd0, 24'h0A0000);
      dq.push_back(24'h000A00); exp_step(2'd1, 24'h000A00);
    end
    pulse_start();
    drain();
    pulse_stop();
    cyc(2);
    probe("stop_keeps_idx", M_BUSY | M_STEP | M_IDX | M_DUTY, 28'h1000A00);

    // Down-ramp from (5,5,5) to (2,8,0)
    wr(2'd0, 24'h050505);
    last_idx = 2'd0;
    dq.push_back(24'h050505); exp_step(2'd0, 24'h050505);
    pulse_start();
    drain();
    pulse_stop();
    cyc(2);
    wr(2'd0, 24'h020800);
    snap = 1'b0;
    dq.push_back(24'h040604); dq.push_back(24'h030703); dq.push_back(24'h020802);
    dq.push_back(24'h020801); dq.push_back(24'h020800);
    exp_step(2'd0, 24'h020800);
    pulse_start();
    drain();
    pulse_stop();
    cyc(2);

    // Stop mid-ramp at red=7, then resume from the frozen value
    wr(2'd0, 24'h0F0000);
    dq.push_back(24'h030700); dq.push_back(24'h040600); dq.push_back(24'h050500);
    dq.push_back(24'h060400); dq.push_back(24'h070300);
    pulse_start();
    drain();
    pulse_stop();
    cyc(20);
    probe("stop_freeze", M_BUSY | M_DUTY, 28'h0070300);
    dq.push_back(24'h080200); dq.push_back(24'h090100); dq.push_back(24'h0A0000);
    for (int r = 11; r <= 15; r++) dq.push_back({8'(r), 16'h0000});
    exp_step(2'd0, 24'h0F0000);
    pulse_start();
    cyc(2);
    probe("restart_from_frozen", M_BUSY | M_IDX | M_DUTY, 28'h8070300);
    drain();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    cyc(2);
    probe("start_stop_idle", M_BUSY | M_STEP | M_DUTY, 28'h00F0000);

    // Live rewrite of the current target redirects the ramp
    wr(2'd1, 24'h800000);
    last_idx = 2'd1;
    exp_step(2'd0, 24'h0F0000);
    for (int r = 16; r <= 32; r++) dq.push_back({8'(r), 16'h0000});
    pulse_start();
    drain();
    wr(2'd1, 24'h100000);
    for (int r = 31; r >= 16; r--) dq.push_back({8'(r), 16'h0000});
    exp_step(2'd1, 24'h100000);
    drain();
    pulse_stop();
    cyc(2);

    // Asynchronous reset in the middle of a fade
    wr(2'd0, 24'h400000);
    last_idx = 2'd0;
    dq.push_back(24'h110000); dq.push_back(24'h120000);
    pulse_start();
    drain();
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    probe("async_reset_mid_fade", M_ALL, 28'h0);
    reset = 1'b0;
    cyc();
    mon_en = 1'b1;

    // Palette entries 0 and 1 read back as zero: both steps complete without any duty change
    last_idx = 2'd1; snap = 1'b1;
    exp_step(2'd0, 24'h000000);
    exp_step(2'd1, 24'h000000);
    pulse_start();
    drain();
    pulse_stop();
    cyc(2);
    probe("palette_cleared_idle", M_BUSY | M_IDX | M_DUTY, 28'h1000000);

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Sequences the 8-bit red/green/blue duty values fed to the RGB LED PWM driver.
- Holds a 4-entry colour palette written by the host.
- Steps through palette entries 0..last_idx, ramping each channel by 1 LSB per fade tick toward the target, holds the target, then advances with wrap-around.
- Sits between the music-box control logic and the PWM driver; it owns the duty inputs of that driver.

Parameters:
- TICK_DIV, 50000, clk cycles per fade tick (>=2); tick counter width = $clog2(TICK_DIV).
- HOLD_TICKS, 200, fade ticks the target colour is held before advancing (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  palette write strobe
- wr_addr  input  2  palette entry to write
- wr_color  input  24  {R[23:16],G[15:8],B[7:0]} written on wr_en
- last_idx  input  2  highest palette index used in the sequence
- snap  input  1  1 = jump directly to the target with no ramp; 0 = ramp
- start  input  1  single-cycle pulse, begin or restart the sequence
- stop  input  1  single-cycle pulse, freeze the outputs and go idle
- duty_red  output  8  red duty to the PWM driver
- duty_green  output  8  green duty
- duty_blue  output  8  blue duty
- color_idx  output  2  palette index currently targeted
- busy  output  1  high in FADE or HOLD
- step_done  output  1  one-cycle pulse when a target colour is reached

Behaviour:
- Reset (async, asserted): palette = all 0; duty_* = 0; color_idx = 0; busy = 0; step_done = 0; tick counter = 0; hold counter = 0; state = IDLE.
- Tick generator: free-running while busy; tick asserts for 1 cycle when the counter reaches TICK_DIV-1, then the counter wraps to 0. The counter clears on start and whenever state = IDLE.
- Palette writes take effect the cycle after wr_en, in any state. If the entry being written is the current target, the new value becomes the target on the next tick; the in-progress ramp redirects toward it.
- IDLE:
  - duty_* hold their last value.
  - start -> FADE with color_idx = 0, tick counter = 0.
- FADE:
  - On each tick, each channel independently moves +1 if below target, -1 if above, unchanged if equal.
  - When snap = 1, on the tick all channels load the target directly.
  - The cycle after all three channels equal the target: step_done = 1, hold counter = 0, state -> HOLD. If the duty values already equal the target on entry, this happens on the first tick.
  - Worst-case ramp is 255 ticks per colour.
- HOLD:
  - The hold counter increments per tick.
  - On the tick where the count reaches HOLD_TICKS-1: color_idx <= (color_idx == last_idx) ? 0 : color_idx+1, state -> FADE.
  - If last_idx decreases below color_idx mid-sequence, the next advance wraps to 0.
- stop: in any state -> IDLE next cycle; duty_* frozen; color_idx retained; step_done is not asserted.
- start while busy: restarts at color_idx = 0, state FADE, counters cleared. duty_* are not cleared; the ramp begins from the present values.
- start and stop in the same cycle: stop wins.
- Reset mid-operation: immediate return to reset values, including the palette.
- Duty arithmetic never wraps: 0 does not decrement and 255 does not increment, because moves only occur toward an in-range target.
- All outputs are registered. Latency from a tick to the duty change is 1 cycle.

Test Plan:
- Reset check: assert reset mid-FADE -> all outputs 0, busy 0 immediately (asynchronous), palette reads back 0.
- Basic ramp: TICK_DIV=4, HOLD_TICKS=2, entry0 = 0x030100, last_idx=0, snap=0, start -> duty_red 1,2,3 on ticks 1..3; duty_green = 1 from tick 1; step_done pulses after tick 3; color_idx stays 0 after hold.
- Wrap: entries 0x0A0000 and 0x000A00, last_idx=1, snap=1 -> duty alternates between (10,0,0) and (0,10,0); color_idx sequence 0,1,0,1; step_done pulses once per colour.
- Down-ramp: duty at (5,5,5), target 0x020800 -> red steps down 5,4,3,2 while green steps up 5..8 and blue steps down to 0; step_done only after all three channels match.
- Stop/start: stop mid-ramp at duty_red=7 -> duty frozen at 7, busy 0; later start -> color_idx 0, ramp resumes from 7. Start and stop asserted together -> IDLE.
- Live palette write: while fading to entry1 = 0x800000, write entry1 = 0x100000 at duty_red=0x20 -> red ramps down to 0x10, then step_done pulses.
